// File: rtl/p4_router_vnp4_ingress_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS AXI-Stream ingress ports into one
// VNP4 packet stream, tagging each packet with its ingress port and counting packets per port.
module p4_router_vnp4_ingress_arbiter #(
  parameter int NUM_PORTS               = 4,
  parameter int DATA_BYTES              = 64,
  parameter int ING_PORT_METADATA_WIDTH = 4,
  parameter int CNT_WIDTH               = 32
) (
  input  logic                                 clk,
  input  logic                                 aresetn,
  input  logic [NUM_PORTS-1:0]                 in_tvalid,
  output logic [NUM_PORTS-1:0]                 in_tready,
  input  logic [NUM_PORTS*DATA_BYTES*8-1:0]    in_tdata,
  input  logic [NUM_PORTS*DATA_BYTES-1:0]      in_tkeep,
  input  logic [NUM_PORTS-1:0]                 in_tlast,
  output logic                                 out_tvalid,
  input  logic                                 out_tready,
  output logic [DATA_BYTES*8-1:0]              out_tdata,
  output logic [DATA_BYTES-1:0]                out_tkeep,
  output logic                                 out_tlast,
  output logic [ING_PORT_METADATA_WIDTH-1:0]   out_tuser,
  input  logic [NUM_PORTS-1:0]                 port_enable,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]       pkt_count,
  input  logic                                 cnt_clear,
  output logic                                 busy
);

  localparam int DW = DATA_BYTES * 8;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]           state_reg;
  logic [PW-1:0]        grant_reg;
  logic [PW-1:0]        rr_reg;

  logic                 skid_valid_reg;
  logic [DW-1:0]        skid_data_reg;
  logic [DATA_BYTES-1:0] skid_keep_reg;
  logic                 skid_last_reg;
  logic [ING_PORT_METADATA_WIDTH-1:0] skid_user_reg;

  logic [NUM_PORTS-1:0] cand;
  logic                 pick_valid;
  logic [PW-1:0]        pick_idx;
  logic [PW:0]          idx_wide;

  logic                 sel_valid;
  logic                 sel_last;
  logic [DW-1:0]        sel_data;
  logic [DATA_BYTES-1:0] sel_keep;

  logic                 ready_int;
  logic                 accept;
  logic                 accept_last;

  // Walk offsets from highest to lowest so the lowest offset from rr_reg wins.
  always_comb begin
    cand       = in_tvalid & port_enable;
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx_wide   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx_wide = {1'b0, rr_reg} + (PW + 1)'(i);
      if (idx_wide >= (PW + 1)'(NUM_PORTS)) begin
        idx_wide = idx_wide - (PW + 1)'(NUM_PORTS);
      end
      if (cand[idx_wide[PW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = idx_wide[PW-1:0];
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_reg == PW'(p)) begin
        sel_valid = in_tvalid[p];
        sel_last  = in_tlast[p];
        sel_data  = in_tdata[p*DW +: DW];
        sel_keep  = in_tkeep[p*DATA_BYTES +: DATA_BYTES];
      end
    end
  end

  // Ready depends only on registered state, so an upstream valid never loops back into it.
  assign ready_int   = (state_reg == XFER) && !skid_valid_reg;
  assign accept      = ready_int && sel_valid;
  assign accept_last = accept && sel_last;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
      assign in_tready[gi] = ready_int && (grant_reg == PW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      rr_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            grant_reg <= pick_idx;
            state_reg <= XFER;
          end
        end
        default: begin
          if (accept_last) begin
            state_reg <= IDLE;
            rr_reg    <= (grant_reg == PW'(NUM_PORTS - 1)) ? '0 : grant_reg + 1'b1;
          end
        end
      endcase
    end
  end

  // Forward register plus one skid entry: the skid catches the beat accepted in the
  // same cycle the output stalls, and in_tready falls the cycle after it fills.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_tvalid     <= 1'b0;
      out_tdata      <= '0;
      out_tkeep      <= '0;
      out_tlast      <= 1'b0;
      out_tuser      <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_keep_reg  <= '0;
      skid_last_reg  <= 1'b0;
      skid_user_reg  <= '0;
    end else if (out_tready || !out_tvalid) begin
      if (skid_valid_reg) begin
        out_tvalid     <= 1'b1;
        out_tdata      <= skid_data_reg;
        out_tkeep      <= skid_keep_reg;
        out_tlast      <= skid_last_reg;
        out_tuser      <= skid_user_reg;
        skid_valid_reg <= 1'b0;
      end else if (accept) begin
        out_tvalid <= 1'b1;
        out_tdata  <= sel_data;
        out_tkeep  <= sel_keep;
        out_tlast  <= sel_last;
        out_tuser  <= ING_PORT_METADATA_WIDTH'(grant_reg);
      end else begin
        out_tvalid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid_reg <= 1'b1;
      skid_data_reg  <= sel_data;
      skid_keep_reg  <= sel_keep;
      skid_last_reg  <= sel_last;
      skid_user_reg  <= ING_PORT_METADATA_WIDTH'(grant_reg);
    end
  end

  // Saturating per-port counters; a clear wins over a same-cycle increment.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_reg;
      always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
          cnt_reg <= '0;
        end else if (cnt_clear) begin
          cnt_reg <= '0;
        end else if (accept_last && (grant_reg == PW'(gi)) && (cnt_reg != '1)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      assign pkt_count[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg;
    end
  endgenerate

  assign busy = (state_reg == XFER) || out_tvalid;

endmodule

// File: tb/tb_p4_router_vnp4_ingress_arbiter.sv
// Scoreboard bench for the ingress arbiter: drivers feed per-port beat queues, a monitor
// checks every output beat against the per-port expected queues and the expected grant order.
module tb_p4_router_vnp4_ingress_arbiter;

  localparam int NP = 4;
  localparam int DB = 4;
  localparam int DW = DB * 8;
  localparam int UW = 4;
  localparam int CW = 32;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic              clk;
  logic              aresetn;
  logic [NP-1:0]     in_tvalid;
  logic [NP-1:0]     in_tready;
  logic [NP*DW-1:0]  in_tdata;
  logic [NP*DB-1:0]  in_tkeep;
  logic [NP-1:0]     in_tlast;
  logic              out_tvalid;
  logic              out_tready;
  logic [DW-1:0]     out_tdata;
  logic [DB-1:0]     out_tkeep;
  logic              out_tlast;
  logic [UW-1:0]     out_tuser;
  logic [NP-1:0]     port_enable;
  logic [NP*CW-1:0]  pkt_count;
  logic              cnt_clear;
  logic              busy;

  // Small second instance for counter saturation
  logic [1:0]        s_in_tvalid;
  logic [1:0]        s_in_tready;
  logic [2*DW-1:0]   s_in_tdata;
  logic [2*DB-1:0]   s_in_tkeep;
  logic [1:0]        s_in_tlast;
  logic              s_out_tvalid;
  logic [DW-1:0]     s_out_tdata;
  logic [DB-1:0]     s_out_tkeep;
  logic              s_out_tlast;
  logic [UW-1:0]     s_out_tuser;
  logic [7:0]        s_pkt_count;
  logic              s_busy;

  p4_router_vnp4_ingress_arbiter #(
    .NUM_PORTS(NP), .DATA_BYTES(DB), .ING_PORT_METADATA_WIDTH(UW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
    .in_tkeep(in_tkeep), .in_tlast(in_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
    .out_tkeep(out_tkeep), .out_tlast(out_tlast), .out_tuser(out_tuser),
    .port_enable(port_enable), .pkt_count(pkt_count), .cnt_clear(cnt_clear), .busy(busy)
  );

  p4_router_vnp4_ingress_arbiter #(
    .NUM_PORTS(2), .DATA_BYTES(DB), .ING_PORT_METADATA_WIDTH(UW), .CNT_WIDTH(4)
  ) dut_sat (
    .clk(clk), .aresetn(aresetn),
    .in_tvalid(s_in_tvalid), .in_tready(s_in_tready), .in_tdata(s_in_tdata),
    .in_tkeep(s_in_tkeep), .in_tlast(s_in_tlast),
    .out_tvalid(s_out_tvalid), .out_tready(1'b1), .out_tdata(s_out_tdata),
    .out_tkeep(s_out_tkeep), .out_tlast(s_out_tlast), .out_tuser(s_out_tuser),
    .port_enable(2'b11), .pkt_count(s_pkt_count), .cnt_clear(1'b0), .busy(s_busy)
  );

  beat_t drv_q [NP][$];
  beat_t exp_q [NP][$];
  int    order_q[$];

  int    n_pass;
  int    n_total;
  int    serial;
  int    cyc;
  int    gap_exp;
  logic  rdy_level;
  logic  rand_rdy;
  logic [NP-1:0] acc_pend;
  beat_t drv_b;

  logic  in_pkt;
  logic  hold_v;
  logic [41:0] hold_val;
  logic  have_start;
  int    last_start;
  beat_t mon_e;
  int    mon_p;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  function automatic logic [CW-1:0] cnt(input int p);
    return pkt_count[p*CW +: CW];
  endfunction

  task automatic push_pkt(input int p, input int len, input bit ord);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {4'(p), 12'(serial), 8'(i), 8'hA5};
      b.last = (i == len - 1);
      b.keep = b.last ? 4'(4'hF >> (serial % 4)) : 4'hF;
      drv_q[p].push_back(b);
      exp_q[p].push_back(b);
    end
    serial++;
    if (ord) order_q.push_back(p);
  endtask

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int p = 0; p < NP; p++) begin
      if (drv_q[p].size() != 0 || exp_q[p].size() != 0) e = 1'b0;
    end
    return e;
  endfunction

  task automatic wait_drain(input string name, input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (all_empty() && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_drain"}, 64'(ok), 64'd1);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    for (int p = 0; p < NP; p++) begin
      drv_q[p].delete();
      exp_q[p].delete();
    end
    order_q.delete();
    rdy_level   = 1'b1;
    rand_rdy    = 1'b0;
    port_enable = '1;
    gap_exp     = 0;
    cnt_clear   = 1'b0;
    tick();
    tick();
    chk("rst_ctrl", 64'({out_tvalid, out_tlast, busy, |pkt_count, in_tready}), 64'd0);
    chk("rst_data", 64'({out_tdata, out_tkeep, out_tuser}), 64'd0);
    aresetn = 1'b1;
    tick();
  endtask

  // Input drivers: present the head beat of each port queue, pop it once accepted.
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (acc_pend[p] && drv_q[p].size() > 0) void'(drv_q[p].pop_front());
      if (drv_q[p].size() > 0) begin
        drv_b = drv_q[p][0];
        in_tvalid[p]          = 1'b1;
        in_tdata[p*DW +: DW]  = drv_b.data;
        in_tkeep[p*DB +: DB]  = drv_b.keep;
        in_tlast[p]           = drv_b.last;
      end else begin
        in_tvalid[p] = 1'b0;
        in_tlast[p]  = 1'b0;
      end
      acc_pend[p] = in_tvalid[p] & in_tready[p] & aresetn;
    end
    out_tready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_level;
  end

  // Output monitor: scoreboard compare on each handshake, stability check while stalled.
  always @(negedge clk) begin
    #1;
    if (!aresetn) begin
      in_pkt     = 1'b0;
      hold_v     = 1'b0;
      have_start = 1'b0;
    end else begin
      if (hold_v) chk("stall_stable", 64'({out_tvalid, out_tlast, out_tuser, out_tkeep, out_tdata}), 64'(hold_val));
      hold_v   = out_tvalid && !out_tready;
      hold_val = {out_tvalid, out_tlast, out_tuser, out_tkeep, out_tdata};
      if (out_tvalid && out_tready) begin
        mon_p = int'(out_tuser);
        if (!in_pkt) begin
          if (order_q.size() > 0) chk("grant_order", 64'(out_tuser), 64'(order_q.pop_front()));
          if (gap_exp != 0 && have_start) chk("pkt_gap", 64'(cyc - last_start), 64'(gap_exp));
          have_start = 1'b1;
          last_start = cyc;
        end
        in_pkt = !out_tlast;
        if (mon_p >= NP) begin
          chk("tuser_range", 64'(out_tuser), 64'(NP - 1));
        end else if (exp_q[mon_p].size() == 0) begin
          chk("unexpected_beat", 64'(out_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          mon_e = exp_q[mon_p].pop_front();
          chk("beat", 64'({out_tdata, out_tkeep, out_tlast}), 64'(mon_e));
        end
      end
    end
  end

  initial begin
    int   cnt_exp [NP];
    bit   found;
    logic seen_rdy;
    int   n;

    n_pass = 0; n_total = 0; serial = 0; cyc = 0;
    aresetn = 1'b0; cnt_clear = 1'b0; rdy_level = 1'b1; rand_rdy = 1'b0;
    port_enable = '1; gap_exp = 0; acc_pend = '0;
    s_in_tvalid = '0; s_in_tlast = '0; s_in_tdata = '0; s_in_tkeep = '0;

    // All four ports, three 2-beat packets each: strict rotation, 3-cycle packet spacing
    do_reset();
    gap_exp = 3;
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < NP; p++) push_pkt(p, 2, 1'b1);
    wait_drain("t1", 400);
    for (int p = 0; p < NP; p++) chk($sformatf("t1_cnt%0d", p), 64'(cnt(p)), 64'd3);

    // Single requester on port 2, single-beat packets: only the arbitration bubble between
    do_reset();
    gap_exp = 2;
    for (int i = 0; i < 5; i++) push_pkt(2, 1, 1'b1);
    wait_drain("t2", 200);
    for (int p = 0; p < NP; p++) chk($sformatf("t2_cnt%0d", p), 64'(cnt(p)), (p == 2) ? 64'd5 : 64'd0);

    // Port 2 disabled: rotation over 0,1,3 only; port 2 back-pressured until re-enabled
    do_reset();
    port_enable = 4'b1011;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) push_pkt(p, 2, 1'b0);
    for (int r = 0; r < 2; r++) begin
      order_q.push_back(0); order_q.push_back(1); order_q.push_back(3);
    end
    order_q.push_back(2); order_q.push_back(2);
    seen_rdy = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      seen_rdy = seen_rdy | in_tready[2];
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[3].size() == 0 && !busy) begin
        found = 1'b1;
        break;
      end
    end
    chk("t3_others_done", 64'(found), 64'd1);
    chk("t3_p2_ready", 64'(seen_rdy), 64'd0);
    chk("t3_p2_pending", 64'(drv_q[2].size()), 64'd4);
    port_enable = '1;
    wait_drain("t3", 200);
    for (int p = 0; p < NP; p++) chk($sformatf("t3_cnt%0d", p), 64'(cnt(p)), 64'd2);

    // Disable port 1 after its third beat: packet completes, its next packet waits
    do_reset();
    push_pkt(1, 6, 1'b1);
    push_pkt(1, 2, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (drv_q[1].size() == 5) begin
        found = 1'b1;
        break;
      end
    end
    chk("t4_mid_pkt", 64'(found), 64'd1);
    port_enable[1] = 1'b0;
    push_pkt(0, 2, 1'b1);
    order_q.push_back(1);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (exp_q[0].size() == 0 && exp_q[1].size() == 2 && !busy) begin
        found = 1'b1;
        break;
      end
    end
    chk("t4_first_two", 64'(found), 64'd1);
    seen_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen_rdy = seen_rdy | in_tready[1] | out_tvalid;
    end
    chk("t4_p1_held", 64'(seen_rdy), 64'd0);
    chk("t4_p1_pending", 64'(drv_q[1].size()), 64'd2);
    port_enable = '1;
    wait_drain("t4", 100);
    chk("t4_cnt0", 64'(cnt(0)), 64'd1);
    chk("t4_cnt1", 64'(cnt(1)), 64'd2);

    // Output stalled: one beat in the register, one in the skid, then input back-pressure
    do_reset();
    rdy_level = 1'b0;
    push_pkt(3, 4, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    chk("bp_in_tready", 64'(in_tready), 64'd0);
    chk("bp_pending", 64'(drv_q[3].size()), 64'd2);
    chk("bp_valid_busy", 64'({out_tvalid, busy}), 64'd3);
    rdy_level = 1'b1;
    wait_drain("bp", 100);

    // Random out_tready over 200 mixed-length packets on the same reset session
    for (int p = 0; p < NP; p++) cnt_exp[p] = (p == 3) ? 1 : 0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      n = (i * 7 + i / 3) % NP;
      cnt_exp[n]++;
      push_pkt(n, 1 + (i * 3 + i / 4) % 5, 1'b0);
    end
    wait_drain("t5", 20000);
    rand_rdy = 1'b0;
    for (int p = 0; p < NP; p++) chk($sformatf("t5_cnt%0d", p), 64'(cnt(p)), 64'(cnt_exp[p]));

    // cnt_clear coinciding with a tlast acceptance on port 0
    do_reset();
    push_pkt(0, 1, 1'b1);
    wait_drain("t6a", 50);
    chk("t6_cnt_before", 64'(cnt(0)), 64'd1);
    push_pkt(0, 2, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_tvalid[0] && in_tready[0] && in_tlast[0]) begin
        found = 1'b1;
        cnt_clear = 1'b1;
        break;
      end
      tick();
    end
    chk("t6_last_seen", 64'(found), 64'd1);
    @(posedge clk);
    #1;
    cnt_clear = 1'b0;
    wait_drain("t6b", 50);
    chk("t6_cnt_cleared", 64'(cnt(0)), 64'd0);
    push_pkt(0, 1, 1'b1);
    wait_drain("t6c", 50);
    chk("t6_cnt_after", 64'(cnt(0)), 64'd1);

    // 17 packets into a 4-bit counter: holds at 15
    do_reset();
    s_in_tvalid = 2'b01;
    s_in_tlast  = 2'b01;
    s_in_tkeep  = '1;
    s_in_tdata  = '0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (s_in_tready[0]) n++;
      if (n == 17) break;
    end
    chk("sat_accepts", 64'(n), 64'd17);
    tick();
    s_in_tvalid = '0;
    for (int i = 0; i < 3; i++) tick();
    chk("sat_cnt0", 64'(s_pkt_count[3:0]), 64'd15);
    chk("sat_cnt1", 64'(s_pkt_count[7:4]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
